// File: rtl/noc_rx_packet_buffer.sv
// Store-and-forward NoC receive buffer with cut-through fallback for oversize packets.
// Optional per-packet size reporting on out_size is enabled with `define NOC_PKTBUF_SIZE_EN.
module noc_rx_packet_buffer #(
    parameter  int FLIT_WIDTH = 32,
    parameter  int DEPTH      = 16,
    localparam int CNT_W      = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [FLIT_WIDTH-1:0] in_flit,
    input  logic                  in_last,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [FLIT_WIDTH-1:0] out_flit,
    output logic                  out_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CNT_W-1:0]      out_size,
    output logic [CNT_W-1:0]      pkt_count
);
    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic {SAF, CUT} mode_e;

    logic [FLIT_WIDTH:0] mem_q [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]    occ_q, occ_d;
    logic [CNT_W-1:0]    pkt_q, pkt_d;
    mode_e               mode_q;

    logic [FLIT_WIDTH:0] head;
    logic wr_en, rd_en, wr_last, rd_last, enter_cut;

    assign head      = mem_q[rd_ptr_q];
    assign in_ready  = (occ_q != CNT_W'(DEPTH));
    assign out_valid = (mode_q == CUT) ? (occ_q != '0) : (pkt_q != '0);
    assign out_flit  = head[FLIT_WIDTH-1:0];
    assign out_last  = out_valid && head[FLIT_WIDTH];
    assign pkt_count = pkt_q;

    assign wr_en   = in_valid && in_ready;
    assign rd_en   = out_valid && out_ready;
    assign wr_last = wr_en && in_last;
    assign rd_last = rd_en && head[FLIT_WIDTH];
    // Full with no complete packet: the resident packet can never finish in SAF.
    assign enter_cut = (mode_q == SAF) && (occ_q == CNT_W'(DEPTH)) && (pkt_q == '0);

    always_comb begin
        occ_d = occ_q;
        pkt_d = pkt_q;
        case ({wr_en, rd_en})
            2'b10:   occ_d = occ_q + CNT_W'(1);
            2'b01:   occ_d = occ_q - CNT_W'(1);
            default: occ_d = occ_q;
        endcase
        case ({wr_last, rd_last})
            2'b10:   pkt_d = pkt_q + CNT_W'(1);
            2'b01:   pkt_d = pkt_q - CNT_W'(1);
            default: pkt_d = pkt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= {in_last, in_flit};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            pkt_q    <= '0;
            mode_q   <= SAF;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (rd_en) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            occ_q <= occ_d;
            pkt_q <= pkt_d;
            case (mode_q)
                SAF:     if (enter_cut) mode_q <= CUT;
                CUT:     if (rd_last)   mode_q <= SAF;
                default: mode_q <= SAF;
            endcase
        end
    end

`ifdef NOC_PKTBUF_SIZE_EN
    logic [CNT_W-1:0] sz_mem_q [DEPTH];
    logic [PTR_W-1:0] sz_wr_q, sz_rd_q;
    logic [CNT_W-1:0] run_q;
    logic             skip_q;
    logic             sz_push, sz_pop;

    // The packet that forced CUT has no known length, so it never gets an entry.
    assign sz_push  = wr_last && !skip_q;
    assign sz_pop   = rd_last && (mode_q == SAF);
    assign out_size = ((mode_q == SAF) && out_valid) ? sz_mem_q[sz_rd_q] : '0;

    always_ff @(posedge clk) begin
        if (sz_push) sz_mem_q[sz_wr_q] <= run_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sz_wr_q <= '0;
            sz_rd_q <= '0;
            run_q   <= '0;
            skip_q  <= 1'b0;
        end else begin
            if (sz_push) sz_wr_q <= sz_wr_q + PTR_W'(1);
            if (sz_pop)  sz_rd_q <= sz_rd_q + PTR_W'(1);
            if (enter_cut) begin
                skip_q <= 1'b1;
                run_q  <= '0;
            end else if (wr_last) begin
                skip_q <= 1'b0;
                run_q  <= '0;
            end else if (wr_en && !skip_q) begin
                run_q  <= run_q + CNT_W'(1);
            end
        end
    end
`else
    assign out_size = '0;
`endif

endmodule

// File: tb/tb_noc_rx_packet_buffer.sv
// Directed and randomized checks for noc_rx_packet_buffer (FLIT_WIDTH=32, DEPTH=16).
module tb_noc_rx_packet_buffer;
    localparam int FW    = 32;
    localparam int DEPTH = 16;
    localparam int CNT_W = 5;
`ifdef NOC_PKTBUF_SIZE_EN
    localparam bit SZ_EN = 1'b1;
`else
    localparam bit SZ_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [FW-1:0] in_flit;
    logic          in_last, in_valid, in_ready;
    logic [FW-1:0] out_flit;
    logic          out_last, out_valid, out_ready;
    logic [CNT_W-1:0] out_size, pkt_count;

    noc_rx_packet_buffer #(.FLIT_WIDTH(FW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_flit(in_flit), .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready),
        .out_flit(out_flit), .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
        .out_size(out_size), .pkt_count(pkt_count)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [CNT_W-1:0] esz(input int n);
        return SZ_EN ? CNT_W'(n) : '0;
    endfunction

    typedef struct {
        logic [FW-1:0] flit;
        logic          last, iv, ordy;
        logic          e_ird, e_ov;
        logic [FW-1:0] e_flit;
        logic          e_last;
        int            e_pkt, e_sz;
    } vec_t;

    vec_t vt [17];

    function automatic vec_t mk(input logic [FW-1:0] f, input logic l, input logic iv,
                                input logic o, input logic ird, input logic ov,
                                input logic [FW-1:0] ef, input logic el, input int ep, input int es);
        vec_t v;
        v.flit = f; v.last = l; v.iv = iv; v.ordy = o;
        v.e_ird = ird; v.e_ov = ov; v.e_flit = ef; v.e_last = el; v.e_pkt = ep; v.e_sz = es;
        return v;
    endfunction

    initial begin
        rst = 1'b1; in_flit = '0; in_last = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_size", out_size, 0);
        chk("rst_pkt_count", pkt_count, 0);

        // 3-flit packet, then last-flit write/read collision across two packets
        vt[0]  = mk('hA1, 0, 1, 1, 1, 0, 0,     0, 0, 0);
        vt[1]  = mk('hA2, 0, 1, 1, 1, 0, 0,     0, 0, 0);
        vt[2]  = mk('hA3, 1, 1, 1, 1, 0, 0,     0, 0, 0);
        vt[3]  = mk(0,    0, 0, 1, 1, 1, 'hA1,  0, 1, 3);
        vt[4]  = mk(0,    0, 0, 1, 1, 1, 'hA2,  0, 1, 3);
        vt[5]  = mk(0,    0, 0, 1, 1, 1, 'hA3,  1, 1, 3);
        vt[6]  = mk(0,    0, 0, 1, 1, 0, 0,     0, 0, 0);
        vt[7]  = mk('hB0, 0, 1, 0, 1, 0, 0,     0, 0, 0);
        vt[8]  = mk('hB1, 1, 1, 0, 1, 0, 0,     0, 0, 0);
        vt[9]  = mk('hC0, 0, 1, 0, 1, 1, 'hB0,  0, 1, 2);
        vt[10] = mk('hC1, 0, 1, 1, 1, 1, 'hB0,  0, 1, 2);
        vt[11] = mk('hC2, 1, 1, 1, 1, 1, 'hB1,  1, 1, 2);
        vt[12] = mk(0,    0, 0, 0, 1, 1, 'hC0,  0, 1, 3);
        vt[13] = mk(0,    0, 0, 1, 1, 1, 'hC0,  0, 1, 3);
        vt[14] = mk(0,    0, 0, 1, 1, 1, 'hC1,  0, 1, 3);
        vt[15] = mk(0,    0, 0, 1, 1, 1, 'hC2,  1, 1, 3);
        vt[16] = mk(0,    0, 0, 0, 1, 0, 0,     0, 0, 0);

        for (int i = 0; i < 17; i++) begin
            in_flit = vt[i].flit; in_last = vt[i].last; in_valid = vt[i].iv; out_ready = vt[i].ordy;
            #1;
            chk($sformatf("v%0d_in_ready", i), in_ready, vt[i].e_ird);
            chk($sformatf("v%0d_out_valid", i), out_valid, vt[i].e_ov);
            chk($sformatf("v%0d_out_last", i), out_last, vt[i].e_last);
            chk($sformatf("v%0d_pkt_count", i), pkt_count, vt[i].e_pkt);
            chk($sformatf("v%0d_out_size", i), out_size, esz(vt[i].e_sz));
            if (vt[i].e_ov) chk($sformatf("v%0d_out_flit", i), out_flit, vt[i].e_flit);
            step();
        end

        // Fill with 16 single-flit packets, then drain
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            in_flit = FW'('h200 + i); in_last = 1'b1; in_valid = 1'b1;
            #1;
            chk($sformatf("fill%0d_in_ready", i), in_ready, 1);
            step();
        end
        in_valid = 1'b0; in_last = 1'b0;
        #1;
        chk("full_in_ready", in_ready, 0);
        chk("full_pkt_count", pkt_count, 16);
        chk("full_out_valid", out_valid, 1);
        out_ready = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            #1;
            chk($sformatf("drain%0d_in_ready", k), in_ready, (k != 0));
            chk($sformatf("drain%0d_flit", k), {out_valid, out_last, out_flit}, {2'b11, FW'('h200 + k)});
            chk($sformatf("drain%0d_size", k), out_size, esz(1));
            step();
        end
        chk("drained_valid", out_valid, 0);
        chk("drained_pkt_count", pkt_count, 0);

        // 20-flit packet forces cut-through
        begin
            int sent = 0, rcv = 0, cyc = 0;
            logic early = 1'b0, acc, xf;
            out_ready = 1'b1;
            while (rcv < 20 && cyc < 200) begin
                in_valid = (sent < 20); in_flit = FW'('h300 + sent); in_last = (sent == 19);
                #1;
                if (out_valid && sent < DEPTH) early = 1'b1;
                acc = in_valid && in_ready;
                xf  = out_valid && out_ready;
                if (xf) begin
                    chk($sformatf("cut%0d_flit", rcv), {out_last, out_flit}, {(rcv == 19), FW'('h300 + rcv)});
                    chk($sformatf("cut%0d_size", rcv), out_size, 0);
                end
                step();
                cyc++;
                if (acc) sent++;
                if (xf) rcv++;
            end
            in_valid = 1'b0; in_last = 1'b0;
            chk("cut_rcv_count", rcv, 20);
            chk("cut_not_early", early, 0);
            #1;
            chk("cut_end_valid", out_valid, 0);
            chk("cut_end_pkt_count", pkt_count, 0);
            // Back in SAF: a partial packet must stay hidden
            in_valid = 1'b1; in_flit = 'h400; in_last = 1'b0; out_ready = 1'b1;
            step();
            in_flit = 'h401; in_last = 1'b1;
            #1;
            chk("saf_partial_hidden", out_valid, 0);
            step();
            in_valid = 1'b0; in_last = 1'b0;
            #1;
            chk("saf_pkt_head", {out_valid, out_last, out_flit}, {2'b10, FW'('h400)});
            chk("saf_pkt_size", out_size, esz(2));
            step();
            chk("saf_pkt_tail", {out_valid, out_last, out_flit}, {2'b11, FW'('h401)});
            step();
            chk("saf_pkt_done", out_valid, 0);
        end

        // Reset in the middle of a packet
        out_ready = 1'b0;
        in_valid = 1'b1; in_last = 1'b0; in_flit = 'h500;
        step();
        in_flit = 'h501;
        step();
        in_valid = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("mrst_pkt_count", pkt_count, 0);
        chk("mrst_out_valid", out_valid, 0);
        chk("mrst_in_ready", in_ready, 1);
        in_valid = 1'b1; in_flit = 'h555; in_last = 1'b1;
        step();
        in_valid = 1'b0; in_last = 1'b0;
        #1;
        chk("mrst_fresh", {out_valid, out_last, out_flit}, {2'b11, FW'('h555)});
        chk("mrst_fresh_size", out_size, esz(1));
        chk("mrst_fresh_pkt", pkt_count, 1);
        out_ready = 1'b1;
        step();
        chk("mrst_alone", out_valid, 0);
        chk("mrst_alone_pkt", pkt_count, 0);

        // Random traffic against a scoreboard
        begin
            typedef struct packed { logic [FW-1:0] f; logic l; } ent_t;
            ent_t sb [$];
            ent_t e;
            int seq = 0, pleft = 0, nsent = 0, mpkt = 0, cyc = 0;
            logic cv = 1'b0, cl = 1'b0, acc, xf;
            logic [FW-1:0] cf = '0;
            while ((nsent < 1000 || sb.size() != 0 || cv) && cyc < 80000) begin
                if (!cv && nsent < 1000 && $urandom_range(0, 1) == 1) begin
                    if (pleft == 0) pleft = $urandom_range(1, 8);
                    cf = FW'(32'h10000 + seq);
                    cl = (pleft == 1);
                    cv = 1'b1;
                end
                in_valid = cv; in_flit = cf; in_last = cl;
                out_ready = (nsent >= 1000 && !cv) ? 1'b1 : 1'($urandom_range(0, 1));
                #1;
                chk("rnd_state", {out_valid, pkt_count}, {(mpkt != 0), CNT_W'(mpkt)});
                acc = in_valid && in_ready;
                xf  = out_valid && out_ready;
                if (xf) begin
                    chk("rnd_nonempty", (sb.size() != 0), 1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        chk("rnd_flit", {out_flit, out_last}, {e.f, e.l});
                    end
                    if (out_last) mpkt--;
                end
                if (acc) begin
                    sb.push_back({cf, cl});
                    if (cl) mpkt++;
                end
                step();
                cyc++;
                if (acc) begin
                    seq++;
                    pleft--;
                    if (cl) nsent++;
                    cv = 1'b0;
                end
            end
            chk("rnd_all_sent", nsent, 1000);
            chk("rnd_drained", sb.size(), 0);
            chk("rnd_end_pkt", pkt_count, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
